cp0_intr_ctrl: RTL and testbench
================================

// Module: cp0_intr_ctrl
// PURPOSE
//  Parametrised coprocessor-0 interrupt/exception controller for the single-cycle CPU; successor to the fixed 1-line unit.
//  Owns STATUS/CAUSE/EPC, NUM_IRQ maskable lines (per-line level/edge), a fixed-priority encoder, vectored entry and a
//  STK_DEPTH-deep STATUS stack for nested handlers. Sits beside the main decoder: takes qualified sync-exception strobes, returns exc/vector/epc for PC select.
// PARAMETERS
//  NUM_IRQ    4            external interrupt lines, 1..8
//  EDGE_MASK  {NUM_IRQ{0}} bit i=1: line i rising-edge sensitive, else level
//  STK_DEPTH  2            STATUS save-stack entries, 1..4
//  VEC_BASE   32'h00000008 sync-exception entry; IRQ i entry = VEC_BASE+32'h20+8*i
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  irq        in   NUM_IRQ external interrupt requests
//  i_syscall  in   1       decoded syscall this cycle
//  i_unimpl   in   1       decoded unimplemented instruction
//  ovr        in   1       ALU overflow on add/sub/addi
//  inst_pc    in   32      PC of current instruction
//  next_pc    in   32      PC current instruction would hand on
//  c0_we      in   1       mtc0 this cycle
//  eret       in   1       eret this cycle
//  c0_addr    in   5       rd field of mtc0/mfc0
//  c0_wdata   in   32      mtc0 source data
//  c0_rdata   out  32      mfc0 read data (comb.)
//  exc        out  1       take exception/interrupt now (comb.)
//  inta       out  1       interrupt acknowledged this cycle (comb.)
//  exc_vec    out  32      entry PC when exc=1
//  epc        out  32      EPC register, used by eret PC select
// BEHAVIOUR
//  Reset: STATUS/CAUSE/EPC=0, stack empty, pending=0, irq_q<=irq (no false edge after reset); exc, inta=0.
//  STATUS(12): [0] IE, [1] sys en, [2] unimpl en, [3] ovr en, [8+i] IM_i; other bits read 0.
//  CAUSE(13): [5:2] ExcCode (0 int,1 sys,2 unimpl,3 ovr), [18:16] IRQ id, [8+i] IP_i (read), [30] stack underflow, [31] overflow (both sticky).
//  EPC(14); mfc0 other addresses -> 0.
//  Pending: level line: IP_i=irq_i. Edge line: set on irq_i&~irq_q_i; cleared on its inta, or mtc0 CAUSE write-1 to bit 8+i.
//  Set wins over same-cycle clear.
//  Request: sync = sta[1]&i_syscall | sta[2]&i_unimpl | sta[3]&ovr; int = IE & |(IP&IM) & ~c0_we & ~eret (deferred one instruction).
//  Priority: ovr > unimpl > sys > interrupts; lowest IRQ index highest. exc = sync|int; inta = int&~sync.
//  Entry edge: push STATUS, clear STATUS[3:0], write CAUSE code/id, EPC = inst_pc (sync, instr suppressed) or next_pc (int, instr completes).
//  Zero-latency decision, one-edge register update.
//  Stack full on entry: drop oldest, set CAUSE[31]. eret: pop into STATUS; empty stack -> STATUS=0, set CAUSE[30]; EPC unchanged.
//  mtc0 writes STATUS/EPC, and CAUSE only [31:30] (W0C) and IP W1C; mtc0 dropped if sync exc same cycle.
//  eret and exc never both (eret is neither unimpl nor ovr).
//  rst mid-handler: all state reset per above; stack contents discarded.
// STRUCTURE
//  cp0_defs.vh: register addresses 12/13/14, ExcCode values, STATUS/CAUSE bit positions.
//  Sub-module cp0_status_stack (push/pop/full/empty, drop-oldest on push when full); rest inline.
// TESTING
//  1 NUM_IRQ=4, STATUS=32'h0F01, level irq[2]=1 -> exc=inta=1, exc_vec=VEC_BASE+0x30, EPC=next_pc, CAUSE[18:16]=2, STATUS[3:0]=0.
//  2 irq[1] and irq[3] together, IM all set -> id 1 taken; after eret restores IE, id 3 taken next.
//  3 ovr=1 with STATUS[3]=1 and irq pending -> exc_vec=VEC_BASE, ExcCode=3, EPC=inst_pc, inta=0.
//  4 Edge line 0: 1-cycle pulse while IE=0 -> IP0 stays set; mtc0 CAUSE 32'h100 clears it; no exc.
//  5 STK_DEPTH=2: three nested entries -> CAUSE[31]=1; three erets -> last sets CAUSE[30], STATUS=0.
//  6 rst asserted mid-handler with irq held high (edge mode) -> all regs 0, no pending after reset release.

Source files
------------

// File: rtl/cp0_intr_ctrl_pkg.sv
// CP0 register addresses, exception codes and STATUS/CAUSE field positions,
// shared by the interrupt controller and anything that decodes CP0 state.
package cp0_intr_ctrl_pkg;

    localparam logic [4:0] C0_STATUS = 5'd12;
    localparam logic [4:0] C0_CAUSE  = 5'd13;
    localparam logic [4:0] C0_EPC    = 5'd14;

    typedef enum logic [3:0] {
        EXC_INT    = 4'd0,
        EXC_SYS    = 4'd1,
        EXC_UNIMPL = 4'd2,
        EXC_OVR    = 4'd3
    } exc_code_e;

    localparam int ST_IE      = 0;
    localparam int ST_SYS_EN  = 1;
    localparam int ST_UNI_EN  = 2;
    localparam int ST_OVR_EN  = 3;
    localparam int ST_IM_LSB  = 8;

    localparam int CA_CODE_LSB = 2;
    localparam int CA_IP_LSB   = 8;
    localparam int CA_ID_LSB   = 16;
    localparam int CA_UNF      = 30;
    localparam int CA_OVF      = 31;

    localparam logic [31:0] IRQ_VEC_OFS = 32'h20;

    // Interrupt handlers sit 8 bytes apart above the sync-exception entry.
    function automatic logic [31:0] irq_vector(input logic [31:0] base, input logic [2:0] id);
        return base + IRQ_VEC_OFS + {26'd0, id, 3'd0};
    endfunction

endpackage

// File: rtl/cp0_status_stack.sv
// STATUS save stack for nested handlers; a push onto a full stack discards
// the oldest entry so the most recent contexts are always preserved.
module cp0_status_stack #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    cnt_q, cnt_d;

    assign top   = mem_q[0];
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

    // Entry 0 is the top; entries shift down on push and up on pop.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (push) begin
            for (int i = DEPTH - 1; i > 0; i--) mem_d[i] = mem_q[i-1];
            mem_d[0] = din;
            if (!full) cnt_d = cnt_q + 1'b1;
        end else if (pop && !empty) begin
            for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // NOTE: storage is deliberately not reset; the count alone defines validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cp0_intr_ctrl.sv
// Coprocessor-0 exception/interrupt controller: STATUS/CAUSE/EPC, maskable
// level/edge IRQ lines, fixed-priority selection and vectored entry.
module cp0_intr_ctrl
    import cp0_intr_ctrl_pkg::*;
#(
    parameter int                 NUM_IRQ   = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
    parameter int                 STK_DEPTH = 2,
    parameter logic [31:0]        VEC_BASE  = 32'h0000_0008
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               i_syscall,
    input  logic               i_unimpl,
    input  logic               ovr,
    input  logic [31:0]        inst_pc,
    input  logic [31:0]        next_pc,
    input  logic               c0_we,
    input  logic               eret,
    input  logic [4:0]         c0_addr,
    input  logic [31:0]        c0_wdata,
    output logic [31:0]        c0_rdata,
    output logic               exc,
    output logic               inta,
    output logic [31:0]        exc_vec,
    output logic [31:0]        epc
);

    localparam logic [31:0] STATUS_MASK =
        32'h0000_000F | (((32'd1 << NUM_IRQ) - 32'd1) << ST_IM_LSB);

    logic [31:0]        status_q, status_d;
    logic [31:0]        epc_q, epc_d;
    exc_code_e          code_q, code_d;
    logic [2:0]         id_q, id_d;
    logic               ovf_q, ovf_d, unf_q, unf_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d, irq_q;

    logic [NUM_IRQ-1:0] ip, irq_hit, irq_clr;
    logic [2:0]         irq_sel;
    logic               sync_exc, int_req;
    exc_code_e          sync_code;
    logic [31:0]        cause_rd;
    logic               stk_push, stk_pop, stk_full, stk_empty;
    logic [31:0]        stk_top;

    cp0_status_stack #(.DEPTH(STK_DEPTH), .WIDTH(32)) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (status_q),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Zero-latency decision: everything below is combinational on current state.
    always_comb begin
        ip      = (irq & ~EDGE_MASK) | (pend_q & EDGE_MASK);
        irq_hit = ip & status_q[ST_IM_LSB +: NUM_IRQ];
        irq_sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_hit[i]) irq_sel = 3'(i);
        end
        sync_exc = (status_q[ST_SYS_EN] & i_syscall) | (status_q[ST_UNI_EN] & i_unimpl)
                 | (status_q[ST_OVR_EN] & ovr);
        // An interrupt waits out an mtc0/eret so the new STATUS takes effect first.
        int_req  = status_q[ST_IE] & (|irq_hit) & ~c0_we & ~eret;
        exc      = sync_exc | int_req;
        inta     = int_req & ~sync_exc;
        if (status_q[ST_OVR_EN] && ovr)         sync_code = EXC_OVR;
        else if (status_q[ST_UNI_EN] && i_unimpl) sync_code = EXC_UNIMPL;
        else                                    sync_code = EXC_SYS;
        exc_vec  = sync_exc ? VEC_BASE : irq_vector(VEC_BASE, irq_sel);
    end

    always_comb begin
        cause_rd                          = '0;
        cause_rd[CA_CODE_LSB +: 4]        = code_q;
        cause_rd[CA_IP_LSB +: NUM_IRQ]    = ip;
        cause_rd[CA_ID_LSB +: 3]          = id_q;
        cause_rd[CA_UNF]                  = unf_q;
        cause_rd[CA_OVF]                  = ovf_q;
        case (c0_addr)
            C0_STATUS: c0_rdata = status_q;
            C0_CAUSE:  c0_rdata = cause_rd;
            C0_EPC:    c0_rdata = epc_q;
            default:   c0_rdata = '0;
        endcase
    end

    assign epc = epc_q;

    always_comb begin
        status_d = status_q;
        epc_d    = epc_q;
        code_d   = code_q;
        id_d     = id_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;

        irq_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (inta && irq_sel == 3'(i)) irq_clr[i] = 1'b1;
        end
        if (c0_we && !sync_exc && c0_addr == C0_CAUSE) irq_clr |= c0_wdata[CA_IP_LSB +: NUM_IRQ];
        // A fresh edge outranks any same-cycle clear.
        pend_d = ((pend_q & ~irq_clr) | (irq & ~irq_q)) & EDGE_MASK;

        if (exc) begin
            stk_push      = 1'b1;
            status_d[3:0] = '0;
            ovf_d         = ovf_q | stk_full;
            if (sync_exc) begin
                code_d = sync_code;
                epc_d  = inst_pc;
            end else begin
                code_d = EXC_INT;
                id_d   = irq_sel;
                epc_d  = next_pc;
            end
        end else if (eret) begin
            stk_pop  = 1'b1;
            status_d = stk_empty ? '0 : stk_top;
            unf_d    = unf_q | stk_empty;
        end else if (c0_we) begin
            case (c0_addr)
                C0_STATUS: status_d = c0_wdata & STATUS_MASK;
                C0_CAUSE: begin
                    ovf_d = ovf_q & c0_wdata[CA_OVF];
                    unf_d = unf_q & c0_wdata[CA_UNF];
                end
                C0_EPC:    epc_d = c0_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
            epc_q    <= '0;
            code_q   <= EXC_INT;
            id_q     <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            pend_q   <= '0;
        end else begin
            status_q <= status_d;
            epc_q    <= epc_d;
            code_q   <= code_d;
            id_q     <= id_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            pend_q   <= pend_d;
        end
        // Tracking irq through reset means a line held high never looks like a new edge.
        irq_q <= irq;
    end

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// Directed and randomized bench for cp0_intr_ctrl against a queue-based
// behavioural model of the CP0 exception/interrupt rules.
module tb_cp0_intr_ctrl;

    localparam int          NIRQ  = 4;
    localparam logic [3:0]  EDGE  = 4'b0001;
    localparam int          DEPTH = 2;
    localparam logic [31:0] VB    = 32'h0000_0008;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq;
    logic        i_syscall, i_unimpl, ovr, c0_we, eret;
    logic [31:0] inst_pc, next_pc, c0_wdata;
    logic [4:0]  c0_addr;
    logic [31:0] c0_rdata, exc_vec, epc;
    logic        exc, inta;

    always #10 clk = ~clk;

    cp0_intr_ctrl #(
        .NUM_IRQ   (NIRQ),
        .EDGE_MASK (EDGE),
        .STK_DEPTH (DEPTH),
        .VEC_BASE  (VB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .i_syscall (i_syscall),
        .i_unimpl  (i_unimpl),
        .ovr       (ovr),
        .inst_pc   (inst_pc),
        .next_pc   (next_pc),
        .c0_we     (c0_we),
        .eret      (eret),
        .c0_addr   (c0_addr),
        .c0_wdata  (c0_wdata),
        .c0_rdata  (c0_rdata),
        .exc       (exc),
        .inta      (inta),
        .exc_vec   (exc_vec),
        .epc       (epc)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [31:0] m_status, m_epc;
    logic [3:0]  m_code;
    logic [2:0]  m_id;
    logic        m_ovf, m_unf;
    logic [3:0]  m_pend, m_prev;
    logic [31:0] m_stack[$];

    // Model predictions for the current cycle.
    logic        e_exc, e_inta, e_sync;
    logic [31:0] e_vec, e_rdata;
    logic [3:0]  e_code;
    int          e_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        logic [3:0] ipv;
        for (int i = 0; i < NIRQ; i++) ipv[i] = EDGE[i] ? m_pend[i] : irq[i];
        e_code = 4'd0;
        if (m_status[3] && ovr)            e_code = 4'd3;
        else if (m_status[2] && i_unimpl)  e_code = 4'd2;
        else if (m_status[1] && i_syscall) e_code = 4'd1;
        e_sync = (e_code != 4'd0);
        e_id = -1;
        for (int i = 0; i < NIRQ; i++) begin
            if (e_id < 0 && ipv[i] && m_status[8+i]) e_id = i;
        end
        e_inta = m_status[0] && (e_id >= 0) && !c0_we && !eret && !e_sync;
        e_exc  = e_sync || (m_status[0] && (e_id >= 0) && !c0_we && !eret);
        e_vec  = e_sync ? VB : VB + 32'h20 + 32'(8 * e_id);
        case (c0_addr)
            5'd12:   e_rdata = m_status;
            5'd13:   e_rdata = {m_ovf, m_unf, 11'b0, m_id, 4'b0, ipv, 2'b0, m_code, 2'b0};
            5'd14:   e_rdata = m_epc;
            default: e_rdata = 32'd0;
        endcase
    endtask

    task automatic model_commit();
        if (rst) begin
            m_status = '0; m_epc = '0; m_code = '0; m_id = '0;
            m_ovf = 1'b0; m_unf = 1'b0; m_pend = '0;
            m_stack.delete();
        end else begin
            for (int i = 0; i < NIRQ; i++) begin
                if (!EDGE[i]) m_pend[i] = 1'b0;
                else if (irq[i] && !m_prev[i]) m_pend[i] = 1'b1;
                else if ((e_inta && e_id == i) ||
                         (c0_we && !e_sync && c0_addr == 5'd13 && c0_wdata[8+i]))
                    m_pend[i] = 1'b0;
            end
            if (e_exc) begin
                if (m_stack.size() == DEPTH) begin
                    void'(m_stack.pop_back());
                    m_ovf = 1'b1;
                end
                m_stack.push_front(m_status);
                m_status[3:0] = 4'd0;
                m_code = e_code;
                if (e_sync) m_epc = inst_pc;
                else begin
                    m_id  = 3'(e_id);
                    m_epc = next_pc;
                end
            end else if (eret) begin
                if (m_stack.size() == 0) begin
                    m_status = '0;
                    m_unf = 1'b1;
                end else m_status = m_stack.pop_front();
            end else if (c0_we) begin
                if (c0_addr == 5'd12) m_status = c0_wdata & 32'h0000_0F0F;
                if (c0_addr == 5'd13) begin
                    m_ovf = m_ovf & c0_wdata[31];
                    m_unf = m_unf & c0_wdata[30];
                end
                if (c0_addr == 5'd14) m_epc = c0_wdata;
            end
        end
        m_prev = irq;
    endtask

    task automatic settle();
        #1;
        model_eval();
        check("exc",   {31'd0, exc},  {31'd0, e_exc});
        check("inta",  {31'd0, inta}, {31'd0, e_inta});
        check("epc",   epc, m_epc);
        check("rdata", c0_rdata, e_rdata);
        if (e_exc) check("vec", exc_vec, e_vec);
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic idle();
        i_syscall = 1'b0; i_unimpl = 1'b0; ovr = 1'b0;
        c0_we = 1'b0; eret = 1'b0; c0_addr = 5'd0; c0_wdata = 32'd0;
    endtask

    task automatic rd(input logic [4:0] a);
        c0_addr = a;
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        c0_we = 1'b1; c0_addr = a; c0_wdata = d;
        settle();
        tick();
        idle();
    endtask

    task automatic do_eret();
        idle();
        eret = 1'b1;
        settle();
        tick();
        idle();
    endtask

    initial begin
        rst = 1'b1; irq = 4'd0; inst_pc = 32'h100; next_pc = 32'h104;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        settle();
        rd(5'd12); check("rst_status", c0_rdata, 32'd0);
        rd(5'd13); check("rst_cause",  c0_rdata, 32'd0);
        rd(5'd14); check("rst_epc",    c0_rdata, 32'd0);
        check("rst_exc", {31'd0, exc}, 32'd0);
        tick();

        // Level irq[2] taken, vector and CAUSE/EPC/STATUS on entry
        mtc0(5'd12, 32'h0F01);
        irq = 4'b0100; inst_pc = 32'h100; next_pc = 32'h104;
        settle();
        check("t1_exc",  {31'd0, exc},  32'd1);
        check("t1_inta", {31'd0, inta}, 32'd1);
        check("t1_vec",  exc_vec, VB + 32'h30);
        tick();
        rd(5'd13); check("t1_id", {29'd0, c0_rdata[18:16]}, 32'd2);
        rd(5'd12); check("t1_status", c0_rdata, 32'h0F00);
        rd(5'd14); check("t1_epc", c0_rdata, 32'h104);
        irq = 4'd0;
        do_eret();
        rd(5'd12); check("t1_restore", c0_rdata, 32'h0F01);

        // irq[1] and irq[3] together: lowest index first, then 3 after eret
        irq = 4'b1010;
        settle();
        check("t2_vec1", exc_vec, VB + 32'h28);
        tick();
        rd(5'd13); check("t2_id1", {29'd0, c0_rdata[18:16]}, 32'd1);
        irq = 4'b1000;
        do_eret();
        settle();
        check("t2_inta3", {31'd0, inta}, 32'd1);
        check("t2_vec3",  exc_vec, VB + 32'h38);
        tick();
        rd(5'd13); check("t2_id3", {29'd0, c0_rdata[18:16]}, 32'd3);
        irq = 4'd0;
        do_eret();

        // Overflow beats a pending interrupt
        mtc0(5'd12, 32'h0F09);
        irq = 4'b0100; ovr = 1'b1; inst_pc = 32'h200; next_pc = 32'h204;
        settle();
        check("t3_exc",  {31'd0, exc},  32'd1);
        check("t3_inta", {31'd0, inta}, 32'd0);
        check("t3_vec",  exc_vec, VB);
        tick();
        ovr = 1'b0;
        rd(5'd13); check("t3_code", {28'd0, c0_rdata[5:2]}, 32'd3);
        rd(5'd14); check("t3_epc", c0_rdata, 32'h200);
        irq = 4'd0;
        do_eret();

        // Edge line 0 pulse while IE=0 stays pending until W1C
        mtc0(5'd12, 32'h0F00);
        irq = 4'b0001;
        settle(); tick();
        irq = 4'b0000;
        settle(); tick();
        settle();
        rd(5'd13); check("t4_ip0_set", {31'd0, c0_rdata[8]}, 32'd1);
        check("t4_noexc", {31'd0, exc}, 32'd0);
        tick();
        mtc0(5'd13, 32'h0000_0100);
        settle();
        rd(5'd13); check("t4_ip0_clr", {31'd0, c0_rdata[8]}, 32'd0);
        tick();

        // Three nested syscalls on a 2-deep stack, then three erets
        for (int k = 0; k < 3; k++) begin
            mtc0(5'd12, 32'h0000_0002);
            i_syscall = 1'b1; inst_pc = 32'h300 + 32'(4 * k); next_pc = inst_pc + 32'd4;
            settle();
            check("t5_exc", {31'd0, exc}, 32'd1);
            tick();
            idle();
        end
        rd(5'd13); check("t5_ovf", {31'd0, c0_rdata[31]}, 32'd1);
        do_eret();
        rd(5'd12); check("t5_pop1", c0_rdata, 32'h0000_0002);
        do_eret();
        do_eret();
        rd(5'd12); check("t5_status0", c0_rdata, 32'd0);
        rd(5'd13); check("t5_unf", {31'd0, c0_rdata[30]}, 32'd1);

        // Reset mid-handler with edge line 0 held high
        mtc0(5'd13, 32'd0);
        mtc0(5'd12, 32'h0101);
        irq = 4'b0001;
        settle(); tick();
        settle();
        check("t6_exc", {31'd0, exc}, 32'd1);
        tick();
        rst = 1'b1;
        settle(); tick();
        settle(); tick();
        rst = 1'b0;
        settle();
        rd(5'd12); check("t6_status", c0_rdata, 32'd0);
        rd(5'd13); check("t6_cause",  c0_rdata, 32'd0);
        rd(5'd14); check("t6_epc",    c0_rdata, 32'd0);
        tick();
        mtc0(5'd12, 32'h0101);
        settle();
        check("t6_nopend", {31'd0, exc}, 32'd0);
        tick();
        irq = 4'd0;

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            idle();
            if ($urandom_range(0, 3) == 0) irq = 4'($urandom);
            inst_pc = $urandom & 32'hFFFF_FFFC;
            next_pc = inst_pc + 32'd4;
            c0_addr = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 2));
            case ($urandom_range(0, 11))
                0: i_syscall = 1'b1;
                1: i_unimpl = 1'b1;
                2: ovr = 1'b1;
                3, 4, 5: begin
                    c0_we = 1'b1;
                    c0_wdata = $urandom;
                end
                6: begin
                    c0_we = 1'b1; i_unimpl = 1'b1;
                    c0_wdata = $urandom;
                end
                7, 8: eret = 1'b1;
                default: ;
            endcase
            rst = ($urandom_range(0, 99) == 0);
            settle();
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
